// File: rtl/ro_window_counter.sv
// Windowed rising-edge counter for an asynchronous ring-oscillator input.
// Define ROWC_SATURATE_EN to saturate the edge count; otherwise it wraps.
module ro_window_counter #(
    parameter int WIDTH       = 16,
    parameter int WINDOW      = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             osc_in,
    input  logic             en,
    input  logic             start,
    input  logic             continuous,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

    localparam int CMAX = (WINDOW > SYNC_STAGES) ? WINDOW : SYNC_STAGES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   edge_det;
    logic [CW-1:0]          win_cnt;
    logic [WIDTH-1:0]       edge_cnt, cnt_nxt;
    logic                   ovf_flag, ovf_nxt;
    logic                   settle_end, win_end;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], osc_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign edge_det   = sync[SYNC_STAGES-1] & ~hist;
    // win_cnt doubles as the settle timer; it restarts on every state change
    assign settle_end = (win_cnt == CW'(SYNC_STAGES - 1));
    assign win_end    = (win_cnt == CW'(WINDOW - 1));

    always_ff @(posedge clk1) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = SETTLE;
                SETTLE:  if (settle_end) state_nxt = COUNT;
                COUNT:   if (win_end) state_nxt = DONE;
                DONE:    state_nxt = continuous ? COUNT : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        count_valid = (state == DONE);
    end

    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = ovf_flag;
        if (edge_det) begin
`ifdef ROWC_SATURATE_EN
            if (edge_cnt == '1) ovf_nxt = 1'b1;
            else                cnt_nxt = edge_cnt + 1'b1;
`else
            cnt_nxt = edge_cnt + 1'b1;
            if (edge_cnt == '1) ovf_nxt = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (state_nxt != state)
                win_cnt <= '0;
            else if (state == SETTLE || state == COUNT)
                win_cnt <= win_cnt + 1'b1;

            // Accumulate only while the window stays open; any exit discards it
            if (state == COUNT && state_nxt == COUNT) begin
                edge_cnt <= cnt_nxt;
                ovf_flag <= ovf_nxt;
            end else begin
                edge_cnt <= '0;
                ovf_flag <= 1'b0;
            end
        end
    end

    // Result includes the edge seen in the final COUNT cycle
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (state == COUNT && state_nxt == DONE) begin
            count    <= cnt_nxt;
            overflow <= ovf_nxt;
        end
    end

endmodule
